// File: rtl/rmii_recv.sv
// RMII receive path: preamble/SFD detection, LSB-first dibble-to-byte assembly, frame status at eof.
// Bytes appear 2 cycles after the 4th dibble is sampled; no backpressure, the MAC must accept every pulse.
module rmii_recv #(
    parameter int MIN_PREAMBLE = 8,
    parameter int MAX_BYTES    = 1522,
    parameter int CNT_W        = 11
) (
    input  logic             PHY_CLK50,
    input  logic             reset,
    input  logic [1:0]       PHY_RX,
    input  logic             PHY_CRS_DV,
    input  logic             PHY_RX_ER,
    output logic [7:0]       data,
    output logic             data_valid,
    output logic             sof,
    output logic             eof,
    output logic             err,
    output logic [CNT_W-1:0] byte_count,
    output logic             active
);

    localparam int PW = $clog2(MIN_PREAMBLE + 1);
    localparam logic [PW-1:0]    PRE_MIN = PW'(MIN_PREAMBLE);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_OVERSIZE,
        S_END,
        S_DROP
    } state_t;

    state_t           r_state;
    logic [1:0]       r_rx;
    logic             r_crs;
    logic             r_crs_prev;
    logic             r_er;
    logic [PW-1:0]    r_pre_cnt;
    logic [1:0]       r_pend;
    logic             r_pend_vld;
    logic [7:0]       r_shift;
    logic [1:0]       r_phase;
    logic [CNT_W-1:0] r_count;
    logic             r_err_sticky;
    logic             w_carrier_end;
    logic [7:0]       w_next_byte;

    // Input registers run freely so carrier tracking stays correct across a mid-frame reset.
    always_ff @(posedge PHY_CLK50) begin
        r_rx       <= PHY_RX;
        r_crs      <= PHY_CRS_DV;
        r_er       <= PHY_RX_ER;
        r_crs_prev <= r_crs;
    end

    assign w_carrier_end = !r_crs && !r_crs_prev;
    assign w_next_byte   = {r_pend, r_shift[7:2]};

    always_ff @(posedge PHY_CLK50) begin
        if (reset) begin
            r_state      <= S_DROP;
            r_pre_cnt    <= '0;
            r_pend       <= '0;
            r_pend_vld   <= 1'b0;
            r_shift      <= '0;
            r_phase      <= '0;
            r_count      <= '0;
            r_err_sticky <= 1'b0;
            data         <= '0;
            data_valid   <= 1'b0;
            sof          <= 1'b0;
            eof          <= 1'b0;
            err          <= 1'b0;
            byte_count   <= '0;
            active       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_crs) begin
                        r_state   <= S_PREAMBLE;
                        r_pre_cnt <= '0;
                    end
                end
                S_PREAMBLE: begin
                    if (w_carrier_end) begin
                        r_state <= S_IDLE;
                    end else if (r_crs) begin
                        case (r_rx)
                            2'b01: begin
                                if (r_pre_cnt != PRE_MIN)
                                    r_pre_cnt <= r_pre_cnt + 1'b1;
                            end
                            2'b11: begin
                                if (r_pre_cnt >= PRE_MIN) begin
                                    r_state      <= S_DATA;
                                    active       <= 1'b1;
                                    r_phase      <= '0;
                                    r_count      <= '0;
                                    r_err_sticky <= 1'b0;
                                    r_pend_vld   <= 1'b0;
                                end else begin
                                    r_state <= S_DROP;
                                end
                            end
                            2'b10:   r_state <= S_DROP;
                            default: ;
                        endcase
                    end
                end
                S_DATA: begin
                    if (r_er)
                        r_err_sticky <= 1'b1;
                    if (w_carrier_end) begin
                        // The held dibble and the current one both came with CRS_DV=0: discard them.
                        r_state    <= S_END;
                        eof        <= 1'b1;
                        byte_count <= r_count;
                        err        <= r_err_sticky | r_er | (r_phase != 2'd0) | (r_count == '0);
                    end else begin
                        r_pend     <= r_rx;
                        r_pend_vld <= 1'b1;
                        if (r_pend_vld) begin
                            r_shift <= w_next_byte;
                            r_phase <= r_phase + 2'd1;
                            if (r_phase == 2'd3) begin
                                if (r_count == CNT_MAX) begin
                                    r_err_sticky <= 1'b1;
                                    r_state      <= S_OVERSIZE;
                                end else begin
                                    data       <= w_next_byte;
                                    data_valid <= 1'b1;
                                    sof        <= (r_count == '0);
                                    r_count    <= r_count + 1'b1;
                                end
                            end
                        end
                    end
                end
                S_OVERSIZE: begin
                    if (w_carrier_end) begin
                        r_state    <= S_END;
                        eof        <= 1'b1;
                        byte_count <= r_count;
                        err        <= 1'b1;
                    end
                end
                S_END: begin
                    active  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_DROP: begin
                    if (w_carrier_end)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_DROP;
            endcase
        end
    end

endmodule
